// File: rtl/depacketizer_dta_pkg.sv
// Shared types and geometry helpers for the destination-tag-append depacketizer.
// Flit layout is {valid, head, tail, noc dst, noc vc, payload}.
package depacketizer_dta_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  // Control bit positions counted down from the flit MSB.
  localparam int VALID_FROM_MSB = 0;
  localparam int HEAD_FROM_MSB  = 1;
  localparam int TAIL_FROM_MSB  = 2;
  localparam int CTRL_BITS      = 3;

  function automatic int payload_w(input int wf, input int aw, input int vw);
    return wf - CTRL_BITS - aw - vw;
  endfunction

  function automatic int head_data_w(input int pw, input int tw, input int aw, input int vw);
    return pw - tw - aw - vw;
  endfunction

  function automatic int cap_w(input int hdw, input int pw, input int nf);
    return hdw + (nf - 1) * pw;
  endfunction

  // Head payload sub-fields, MSB-first: tag, return dst, return vc, data.
  function automatic int head_tag_hi(input int pw);
    return pw - 1;
  endfunction

  function automatic int head_dst_hi(input int pw, input int tw);
    return pw - 1 - tw;
  endfunction

  function automatic int head_vc_hi(input int pw, input int tw, input int aw);
    return pw - 1 - tw - aw;
  endfunction

  function automatic int head_data_hi(input int pw, input int tw, input int aw, input int vw);
    return pw - 1 - tw - aw - vw;
  endfunction

endpackage

// File: rtl/depacketizer_dta_outreg.sv
// One-entry valid/ready output register holding {data, dst, vc, tag}.
// A load and a drain in the same cycle pass back-to-back without a bubble.
module depacketizer_dta_outreg #(
  parameter int WIDTH_DATA       = 64,
  parameter int ADDRESS_WIDTH    = 4,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int WIDTH_TAG        = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_load,
  input  logic [WIDTH_DATA-1:0]       i_data,
  input  logic [ADDRESS_WIDTH-1:0]    i_dst,
  input  logic [VC_ADDRESS_WIDTH-1:0] i_vc,
  input  logic [WIDTH_TAG-1:0]        i_tag,
  input  logic                        i_ready,
  output logic                        o_ready,
  output logic                        o_valid,
  output logic [WIDTH_DATA-1:0]       o_data,
  output logic [ADDRESS_WIDTH-1:0]    o_dst,
  output logic [VC_ADDRESS_WIDTH-1:0] o_vc,
  output logic [WIDTH_TAG-1:0]        o_tag
);

  logic                        r_valid;
  logic [WIDTH_DATA-1:0]       r_data;
  logic [ADDRESS_WIDTH-1:0]    r_dst;
  logic [VC_ADDRESS_WIDTH-1:0] r_vc;
  logic [WIDTH_TAG-1:0]        r_tag;

  assign o_ready = !r_valid || i_ready;

  // Loads only arrive when o_ready is high, so a load never overwrites an undrained word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_dst   <= '0;
      r_vc    <= '0;
      r_tag   <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_dst   <= i_dst;
      r_vc    <= i_vc;
      r_tag   <= i_tag;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_dst   = r_dst;
  assign o_vc    = r_vc;
  assign o_tag   = r_tag;

endmodule

// File: rtl/depacketizer_dta_n.sv
// N-flit depacketizer with return tag/dst/vc parsing at a NoC egress port.
// Define DEPACKETIZER_DTA_STATS_EN to add saturating packet and error counters.
module depacketizer_dta_n
  import depacketizer_dta_pkg::*;
#(
  parameter int WIDTH_FLIT       = 36,
  parameter int WIDTH_DATA       = 64,
  parameter int ADDRESS_WIDTH    = 4,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int WIDTH_TAG        = 8,
  parameter int NUM_FLITS        = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [WIDTH_FLIT-1:0]       flit_in,
  output logic                        ready_out,
  output logic [WIDTH_DATA-1:0]       data_out,
  output logic [ADDRESS_WIDTH-1:0]    dst_out,
  output logic [VC_ADDRESS_WIDTH-1:0] vc_out,
  output logic [WIDTH_TAG-1:0]        tag_out,
  output logic                        valid_out,
  input  logic                        ready_in,
  output logic                        err_out
`ifdef DEPACKETIZER_DTA_STATS_EN
  ,
  output logic [15:0]                 pkt_count_out,
  output logic [15:0]                 err_count_out
`endif
);

  localparam int PAYLOAD_W   = payload_w(WIDTH_FLIT, ADDRESS_WIDTH, VC_ADDRESS_WIDTH);
  localparam int HEAD_DATA_W = head_data_w(PAYLOAD_W, WIDTH_TAG, ADDRESS_WIDTH, VC_ADDRESS_WIDTH);
  localparam int CAP         = cap_w(HEAD_DATA_W, PAYLOAD_W, NUM_FLITS);
  localparam int CNT_W       = $clog2(NUM_FLITS + 1);
  localparam int TAG_HI      = head_tag_hi(PAYLOAD_W);
  localparam int DST_HI      = head_dst_hi(PAYLOAD_W, WIDTH_TAG);
  localparam int VC_HI       = head_vc_hi(PAYLOAD_W, WIDTH_TAG, ADDRESS_WIDTH);
  localparam int HDATA_HI    = head_data_hi(PAYLOAD_W, WIDTH_TAG, ADDRESS_WIDTH, VC_ADDRESS_WIDTH);

  if (CAP < WIDTH_DATA || HEAD_DATA_W < 1 || NUM_FLITS < 1 || NUM_FLITS > 8) begin : g_param_check
    $error("depacketizer_dta_n: invalid parameter combination");
  end

  logic                        w_valid, w_head, w_tail, w_ready, w_accept;
  logic                        w_full, w_load, w_err_set;
  logic [PAYLOAD_W-1:0]        w_payload;
  logic [WIDTH_TAG-1:0]        w_tag, w_ld_tag;
  logic [ADDRESS_WIDTH-1:0]    w_dst, w_ld_dst;
  logic [VC_ADDRESS_WIDTH-1:0] w_vc, w_ld_vc;
  logic [HEAD_DATA_W-1:0]      w_hdata;
  logic [CAP-1:0]              w_head_buf, w_buf_app;
  logic [WIDTH_DATA-1:0]       w_ld_data;
  logic                        w_unused_route;

  state_t                      r_state;
  logic [CNT_W-1:0]            r_cnt;
  logic                        r_ovf;
  logic                        r_err;
  logic [CAP-1:0]              r_buf;
  logic [WIDTH_TAG-1:0]        r_tag;
  logic [ADDRESS_WIDTH-1:0]    r_dst;
  logic [VC_ADDRESS_WIDTH-1:0] r_vc;

  assign w_valid   = flit_in[WIDTH_FLIT-1-VALID_FROM_MSB];
  assign w_head    = flit_in[WIDTH_FLIT-1-HEAD_FROM_MSB];
  assign w_tail    = flit_in[WIDTH_FLIT-1-TAIL_FROM_MSB];
  assign w_payload = flit_in[PAYLOAD_W-1:0];
  assign w_tag     = w_payload[TAG_HI -: WIDTH_TAG];
  assign w_dst     = w_payload[DST_HI -: ADDRESS_WIDTH];
  assign w_vc      = w_payload[VC_HI -: VC_ADDRESS_WIDTH];
  assign w_hdata   = w_payload[HDATA_HI -: HEAD_DATA_W];
  assign w_accept  = w_valid && w_ready;
  assign w_full    = (r_cnt == CNT_W'(NUM_FLITS));

  // NoC routing fields have already served their purpose at the egress port.
  assign w_unused_route = ^flit_in[WIDTH_FLIT-1-CTRL_BITS : PAYLOAD_W];

  assign w_head_buf = CAP'(w_hdata) << (CAP - HEAD_DATA_W);

  always_comb begin
    w_buf_app = r_buf;
    for (int k = 1; k < NUM_FLITS; k++) begin
      if (r_cnt == CNT_W'(k)) begin
        w_buf_app[CAP-1-HEAD_DATA_W-(k-1)*PAYLOAD_W -: PAYLOAD_W] = w_payload;
      end
    end
  end

  assign w_load = w_accept && w_tail && (w_head || r_state == COLLECT);

  assign w_err_set = w_accept &&
                     ((r_state == IDLE && !w_head) ||
                      (r_state == COLLECT && w_head) ||
                      (r_state == COLLECT && !w_head && w_full && !r_ovf));

  // A head&tail flit bypasses the assembly buffer and feeds the output register directly.
  always_comb begin
    if (w_head) begin
      w_ld_data = w_head_buf[CAP-1 -: WIDTH_DATA];
      w_ld_tag  = w_tag;
      w_ld_dst  = w_dst;
      w_ld_vc   = w_vc;
    end else begin
      w_ld_data = w_buf_app[CAP-1 -: WIDTH_DATA];
      w_ld_tag  = r_tag;
      w_ld_dst  = r_dst;
      w_ld_vc   = r_vc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_err   <= 1'b0;
      r_buf   <= '0;
      r_tag   <= '0;
      r_dst   <= '0;
      r_vc    <= '0;
    end else begin
      r_err <= w_err_set;
      if (w_accept) begin
        if (w_head) begin
          r_ovf <= 1'b0;
          if (w_tail) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_state <= COLLECT;
            r_cnt   <= CNT_W'(1);
            r_buf   <= w_head_buf;
            r_tag   <= w_tag;
            r_dst   <= w_dst;
            r_vc    <= w_vc;
          end
        end else if (r_state == COLLECT) begin
          r_buf <= w_buf_app;
          if (w_full) begin
            r_ovf <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
          if (w_tail) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
          end
        end
      end
    end
  end

  assign err_out = r_err;

  depacketizer_dta_outreg #(
    .WIDTH_DATA      (WIDTH_DATA),
    .ADDRESS_WIDTH   (ADDRESS_WIDTH),
    .VC_ADDRESS_WIDTH(VC_ADDRESS_WIDTH),
    .WIDTH_TAG       (WIDTH_TAG)
  ) u_outreg (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_data (w_ld_data),
    .i_dst  (w_ld_dst),
    .i_vc   (w_ld_vc),
    .i_tag  (w_ld_tag),
    .i_ready(ready_in),
    .o_ready(w_ready),
    .o_valid(valid_out),
    .o_data (data_out),
    .o_dst  (dst_out),
    .o_vc   (vc_out),
    .o_tag  (tag_out)
  );

  assign ready_out = w_ready;

`ifdef DEPACKETIZER_DTA_STATS_EN
  logic [15:0] r_pkt_count;
  logic [15:0] r_err_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt_count <= '0;
      r_err_count <= '0;
    end else begin
      if (w_load && r_pkt_count != 16'hFFFF) r_pkt_count <= r_pkt_count + 16'd1;
      if (w_err_set && r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
    end
  end

  assign pkt_count_out = r_pkt_count;
  assign err_count_out = r_err_count;
`endif

endmodule

// File: tb/tb_depacketizer_dta_n.sv
// Directed bench for depacketizer_dta_n with a scoreboard of expected output words.
module tb_depacketizer_dta_n;

  localparam int WF  = 36;
  localparam int WD  = 64;
  localparam int AW  = 4;
  localparam int VW  = 1;
  localparam int TW  = 8;
  localparam int PW  = 28;
  localparam int HDW = 15;
  localparam int CAP = 99;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [WF-1:0] flit_in;
  logic          ready_out;
  logic [WD-1:0] data_out;
  logic [AW-1:0] dst_out;
  logic [VW-1:0] vc_out;
  logic [TW-1:0] tag_out;
  logic          valid_out;
  logic          ready_in;
  logic          err_out;

  always #5 clk = ~clk;

  depacketizer_dta_n dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flit_in  (flit_in),
    .ready_out(ready_out),
    .data_out (data_out),
    .dst_out  (dst_out),
    .vc_out   (vc_out),
    .tag_out  (tag_out),
    .valid_out(valid_out),
    .ready_in (ready_in),
    .err_out  (err_out)
  );

  typedef struct packed {
    logic [WD-1:0] data;
    logic [AW-1:0] dst;
    logic [VW-1:0] vc;
    logic [TW-1:0] tag;
  } word_t;

  word_t         sbq[$];
  int            checks  = 0;
  int            errors  = 0;
  int            errSeen = 0;
  int            popped  = 0;
  logic [PW-1:0] bodyPay [0:7];

  task automatic checkOutput(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic [WF-1:0] mkHead(input logic [TW-1:0] tag, input logic [AW-1:0] dst,
                                           input logic [VW-1:0] vc, input logic [HDW-1:0] hd,
                                           input logic tail);
    return {1'b1, 1'b1, tail, 4'h0, 1'b0, tag, dst, vc, hd};
  endfunction

  function automatic logic [WF-1:0] mkBody(input logic [PW-1:0] p, input logic tail);
    return {1'b1, 1'b0, tail, 4'h5, 1'b1, p};
  endfunction

  // Holds a flit until it is accepted, then returns just after that clock edge.
  task automatic applyStimulus(input logic [WF-1:0] f);
    int waited = 0;
    flit_in = f;
    @(negedge clk);
    while (ready_out !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (ready_out !== 1'b1) checkOutput("flit_accept_timeout", 128'(ready_out), 128'd1);
    @(posedge clk);
    #1;
    flit_in = '0;
  endtask

  // Expected word keeps the head data plus at most three later payloads, MSB-first.
  task automatic sendPacket(input logic [TW-1:0] tag, input logic [AW-1:0] dst,
                            input logic [VW-1:0] vc, input logic [HDW-1:0] hd, input int nBody);
    logic [PW-1:0]  p0, p1, p2;
    logic [CAP-1:0] full;
    word_t          w;
    p0 = (nBody > 0) ? bodyPay[0] : PW'(0);
    p1 = (nBody > 1) ? bodyPay[1] : PW'(0);
    p2 = (nBody > 2) ? bodyPay[2] : PW'(0);
    full   = {hd, p0, p1, p2};
    w.data = full[CAP-1 -: WD];
    w.dst  = dst;
    w.vc   = vc;
    w.tag  = tag;
    sbq.push_back(w);
    applyStimulus(mkHead(tag, dst, vc, hd, nBody == 0));
    for (int i = 0; i < nBody; i++) applyStimulus(mkBody(bodyPay[i], i == nBody - 1));
  endtask

  task automatic idle(input int n);
    flit_in = '0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while (sbq.size() != 0 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput(name, 128'(sbq.size()), 128'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (err_out === 1'b1) errSeen++;
      if (valid_out === 1'b1 && ready_in === 1'b1) begin
        if (sbq.size() == 0) begin
          checkOutput("sb_unexpected_word", 128'(valid_out), 128'd0);
        end else begin
          word_t e;
          e = sbq.pop_front();
          popped++;
          checkOutput("sb_word", 128'({data_out, dst_out, vc_out, tag_out}), 128'(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base;
    int pbase;
    rst_n    = 1'b0;
    ready_in = 1'b1;
    flit_in  = '0;
    for (int i = 0; i < 8; i++) bodyPay[i] = PW'(32'h0101010 * (i + 1) + 32'h0ABCDE0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_valid", 128'(valid_out), 128'd0);
    checkOutput("rst_err", 128'(err_out), 128'd0);
    checkOutput("rst_data", 128'(data_out), 128'd0);
    checkOutput("rst_fields", 128'({dst_out, vc_out, tag_out}), 128'd0);
    checkOutput("rst_ready_out", 128'(ready_out), 128'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);

    $display("[TB] step 1: four-flit packet");
    base = errSeen;
    bodyPay[0] = 28'h1234567;
    bodyPay[1] = 28'h89ABCDE;
    bodyPay[2] = 28'hFEDCBA9;
    sendPacket(8'hA5, 4'h3, 1'b1, 15'h5A5A, 3);
    @(negedge clk);
    checkOutput("t1_valid_latency", 128'(valid_out), 128'd1);
    checkOutput("t1_tag", 128'(tag_out), 128'hA5);
    waitDrain("t1_drain");
    idle(2);
    checkOutput("t1_no_err", 128'(errSeen - base), 128'd0);

    $display("[TB] step 2: single head&tail flit");
    sendPacket(8'h01, 4'h7, 1'b0, 15'h7ABC, 0);
    @(negedge clk);
    checkOutput("t2_valid", 128'(valid_out), 128'd1);
    checkOutput("t2_data", 128'(data_out), 128'({15'h7ABC, 49'b0}));
    waitDrain("t2_drain");
    idle(1);

    $display("[TB] step 3: output held by ready_in");
    pbase = popped;
    ready_in = 1'b0;
    bodyPay[0] = 28'h3030303;
    sendPacket(8'h33, 4'h9, 1'b1, 15'h1111, 1);
    bodyPay[0] = 28'h4444444;
    bodyPay[1] = 28'h4545454;
    fork
      sendPacket(8'h44, 4'h4, 1'b0, 15'h4321, 2);
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          checkOutput("t3_ready_held", 128'(ready_out), 128'd0);
        end
        checkOutput("t3_valid_held", 128'(valid_out), 128'd1);
        @(posedge clk);
        #1;
        ready_in = 1'b1;
      end
    join
    waitDrain("t3_drain");
    idle(2);
    checkOutput("t3_popped", 128'(popped - pbase), 128'd2);

    $display("[TB] step 4: body flit while idle");
    base = errSeen;
    applyStimulus(mkBody(28'hDEADBEE, 1'b0));
    idle(2);
    checkOutput("t4_err_pulse", 128'(errSeen - base), 128'd1);
    bodyPay[0] = 28'h5555555;
    bodyPay[1] = 28'h5A5A5A5;
    sendPacket(8'h5C, 4'hC, 1'b1, 15'h5005, 2);
    waitDrain("t4_drain");
    idle(2);
    checkOutput("t4_err_total", 128'(errSeen - base), 128'd1);

    $display("[TB] step 5: new head aborts a partial packet");
    base = errSeen;
    applyStimulus(mkHead(8'h11, 4'h1, 1'b0, 15'h0AAA, 1'b0));
    applyStimulus(mkBody(28'h0BADF00, 1'b0));
    bodyPay[0] = 28'h2222222;
    bodyPay[1] = 28'h2323232;
    bodyPay[2] = 28'h2424242;
    sendPacket(8'h22, 4'h2, 1'b1, 15'h2222, 3);
    waitDrain("t5_drain");
    idle(2);
    checkOutput("t5_err_pulse", 128'(errSeen - base), 128'd1);
    checkOutput("t5_last_tag", 128'(tag_out), 128'h22);

    $display("[TB] step 6: overlong packet");
    base = errSeen;
    for (int i = 0; i < 6; i++) bodyPay[i] = PW'(32'h6000001 + 32'h0111111 * i);
    sendPacket(8'h66, 4'h6, 1'b0, 15'h6666, 6);
    waitDrain("t6_drain");
    idle(2);
    checkOutput("t6_err_once", 128'(errSeen - base), 128'd1);

    $display("[TB] step 7: reset mid-packet");
    applyStimulus(mkHead(8'h77, 4'h7, 1'b1, 15'h7777, 1'b0));
    applyStimulus(mkBody(28'h7070707, 1'b0));
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_valid", 128'(valid_out), 128'd0);
    checkOutput("rst_mid_data", 128'(data_out), 128'd0);
    checkOutput("rst_mid_fields", 128'({dst_out, vc_out, tag_out}), 128'd0);
    checkOutput("rst_mid_err", 128'(err_out), 128'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    base = errSeen;
    bodyPay[0] = 28'h8888888;
    bodyPay[1] = 28'h8989898;
    sendPacket(8'h88, 4'hA, 1'b1, 15'h0F0F, 2);
    waitDrain("rst_clean_drain");
    idle(2);
    checkOutput("rst_clean_no_err", 128'(errSeen - base), 128'd0);
    checkOutput("final_sb_empty", 128'(sbq.size()), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
